// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS-subset control FSM with retire counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN traps unsupported instructions instead of skipping them.
module multi_cycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic [15:0] retire_cnt,
    output logic        illegal
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_LUI = 6'b001111;

    state_t     cur, nxt;
    logic [5:0] op_q, func_q;
    logic       retire;

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        // {valid, alu_op} for the R-type function field
        case (f)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b100110: return 4'b1011;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic supported(input logic [5:0] o, input logic [5:0] f);
        return (o == OP_R) ? r_alu(f)[3] : (o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_LUI);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= FETCH;
            op_q       <= '0;
            func_q     <= '0;
            retire_cnt <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q   <= op;
                func_q <= func;
            end
            if (retire) retire_cnt <= retire_cnt + 16'd1;
        end
    end

    always_comb begin
        nxt        = FETCH;
        retire     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        // Reset forces every strobe low even though the state reads FETCH.
        if (rst_n) begin
            case (cur)
                FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                    nxt      = mem_ready ? DECODE : FETCH;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                DECODE: nxt = supported(op, func) ? EXEC : TRAP;
                TRAP:   nxt = TRAP;
`else
                DECODE: nxt = supported(op, func) ? EXEC : FETCH;
`endif
                EXEC: begin
                    alu_src  = (op_q == OP_LW || op_q == OP_SW || op_q == OP_LUI);
                    alu_op   = (op_q == OP_R) ? r_alu(func_q)[2:0] :
                               (op_q == OP_LUI) ? 3'b111 : (op_q == OP_BEQ) ? 3'b110 : 3'b010;
                    pc_src   = (op_q == OP_BEQ);
                    pc_write = (op_q == OP_BEQ) && zero;
                    retire   = (op_q == OP_BEQ);
                    nxt      = (op_q == OP_LW || op_q == OP_SW) ? MEM : (op_q == OP_BEQ) ? FETCH : WB;
                end
                MEM: begin
                    iord      = 1'b1;
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                    retire    = mem_ready && (op_q == OP_SW);
                    nxt       = !mem_ready ? MEM : (op_q == OP_LW) ? WB : FETCH;
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OP_R);
                    mem_to_reg = (op_q == OP_LW);
                    retire     = 1'b1;
                end
                default: nxt = FETCH;
            endcase
        end
    end

    assign state = cur;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (cur == TRAP);
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: randomized instruction traces checked against a per-instruction cycle model.
module tb_multi_cycle_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op = '0, func = '0;
    logic        mem_ready = 1'b0, zero = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src;
    logic        reg_write, reg_dst, mem_to_reg, alu_src, illegal;
    logic [2:0]  alu_op, state;
    logic [15:0] retire_cnt;
    logic [15:0] model_cnt = '0;
    logic [12:0] ctl;
    int          checks = 0, errors = 0;

    multi_cycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .mem_ready(mem_ready), .zero(zero),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .state(state),
        .retire_cnt(retire_cnt), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, alu_src, alu_op};

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] cv(input logic mr, mw, io, irw, pcw, pcs, rw, rd, m2r, as, input logic [2:0] ao);
        return {mr, mw, io, irw, pcw, pcs, rw, rd, m2r, as, ao};
    endfunction

    // 0 unsupported, 1 R-type, 2 lw, 3 sw, 4 beq, 5 lui
    function automatic int kind(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000) return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b100110) ? 1 : 0;
        if (o == 6'b100011) return 2;
        if (o == 6'b101011) return 3;
        if (o == 6'b000100) return 4;
        if (o == 6'b001111) return 5;
        return 0;
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b011;
        endcase
    endfunction

    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z, input int fw, input int mw);
        logic [16:0] q[$];
        int          k = kind(o, f);
        int          dec;
        for (int i = 0; i < fw; i++) q.push_back({1'b0, 3'd0, cv(1,0,0,0,0,0,0,0,0,0,3'b000)});
        q.push_back({1'b1, 3'd0, cv(1,0,0,1,1,0,0,0,0,0,3'b000)});
        dec = q.size();
        q.push_back({1'($urandom), 3'd1, 13'd0});
        case (k)
            1: begin
                q.push_back({1'($urandom), 3'd2, cv(0,0,0,0,0,0,0,0,0,0,r_op(f))});
                q.push_back({1'($urandom), 3'd4, cv(0,0,0,0,0,0,1,1,0,0,3'b000)});
            end
            2, 3: begin
                q.push_back({1'($urandom), 3'd2, cv(0,0,0,0,0,0,0,0,0,1,3'b010)});
                for (int i = 0; i < mw; i++) q.push_back({1'b0, 3'd3, cv(k == 2, k == 3, 1,0,0,0,0,0,0,0,3'b000)});
                q.push_back({1'b1, 3'd3, cv(k == 2, k == 3, 1,0,0,0,0,0,0,0,3'b000)});
                if (k == 2) q.push_back({1'($urandom), 3'd4, cv(0,0,0,0,0,0,1,0,1,0,3'b000)});
            end
            4: q.push_back({1'($urandom), 3'd2, cv(0,0,0,0,z,1,0,0,0,0,3'b110)});
            5: begin
                q.push_back({1'($urandom), 3'd2, cv(0,0,0,0,0,0,0,0,0,1,3'b111)});
                q.push_back({1'($urandom), 3'd4, cv(0,0,0,0,0,0,1,0,0,0,3'b000)});
            end
            default: ;
        endcase
        if (k != 0) model_cnt = model_cnt + 16'd1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            // After DECODE the live op/func are scrambled to prove they were latched.
            op = (i <= dec) ? o : 6'($urandom);
            func = (i <= dec) ? f : 6'($urandom);
            mem_ready = q[i][16];
            zero = z;
            #1;
            checks++;
            if ({illegal, state, ctl} !== {1'b0, q[i][15:0]}) begin
                errors++;
                $display("FAIL %s cycle %0d: got illegal=%b state=%0d ctl=%b, want illegal=0 state=%0d ctl=%b",
                         name, i, illegal, state, ctl, q[i][15:13], q[i][12:0]);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || retire_cnt !== model_cnt) begin
            errors++;
            $display("FAIL %s end: got state=%0d retire_cnt=%h, want state=0 retire_cnt=%h", name, state, retire_cnt, model_cnt);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({state, ctl, retire_cnt, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got state=%0d ctl=%b retire_cnt=%h illegal=%b, want all zero", state, ctl, retire_cnt, illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state, ctl} !== {3'd0, cv(1,0,0,0,0,0,0,0,0,0,3'b000)}) begin
            errors++;
            $display("FAIL reset_release: got state=%0d ctl=%b, want state=0 ctl=%b", state, ctl, cv(1,0,0,0,0,0,0,0,0,0,3'b000));
        end
    endtask

    task automatic test_rtype;
        run_instr("add", 6'b000000, 6'b100000, 1'b0, 0, 0);
        run_instr("sub", 6'b000000, 6'b100010, 1'b1, 1, 0);
        run_instr("and", 6'b000000, 6'b100100, 1'b0, 0, 0);
        run_instr("or",  6'b000000, 6'b100101, 1'b0, 2, 0);
        run_instr("xor", 6'b000000, 6'b100110, 1'b0, 0, 0);
        run_instr("lui", 6'b001111, 6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_mem;
        run_instr("lw_wait2", 6'b100011, 6'b000000, 1'b0, 0, 2);
        run_instr("lw_nowait", 6'b100011, 6'b111111, 1'b0, 0, 0);
        run_instr("sw_nowait", 6'b101011, 6'b000000, 1'b0, 0, 0);
        run_instr("sw_wait3", 6'b101011, 6'b000000, 1'b0, 1, 3);
    endtask

    task automatic test_beq;
        run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr("beq_not_taken", 6'b000100, 6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_illegal;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        @(negedge clk);
        op = 6'b000010;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            op = 6'($urandom);
            #1;
            checks++;
            if ({illegal, state, ctl} !== {1'b1, 3'd5, 13'd0}) begin
                errors++;
                $display("FAIL trap cycle %0d: got illegal=%b state=%0d ctl=%b, want illegal=1 state=5 ctl=0", i, illegal, state, ctl);
            end
        end
        #2 rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({illegal, state, retire_cnt} !== '0) begin
            errors++;
            $display("FAIL trap_reset: got illegal=%b state=%0d retire_cnt=%h, want 0 0 0", illegal, state, retire_cnt);
        end
        model_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
`else
        run_instr("illegal_op", 6'b000010, 6'b000000, 1'b0, 0, 0);
        run_instr("illegal_func", 6'b000000, 6'b101010, 1'b0, 1, 0);
`endif
    endtask

    task automatic test_reset_mid_sw;
        @(negedge clk);
        op = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 3'd3 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem_before_reset: got state=%0d mem_write=%b, want state=3 mem_write=1", state, mem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, ctl, retire_cnt} !== '0) begin
            errors++;
            $display("FAIL sw_mid_reset: got state=%0d ctl=%b retire_cnt=%h, want all zero", state, ctl, retire_cnt);
        end
        model_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL sw_after_reset: got state=%0d mem_read=%b mem_write=%b, want 0 1 0", state, mem_read, mem_write);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001111, 6'b000010};
        logic [5:0] funcs[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
        logic [5:0] o, f;
        for (int n = 0; n < 60; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            o = ops[$urandom_range(0, 4)];
            f = (o == 6'b000000) ? funcs[$urandom_range(0, 4)] : 6'($urandom);
`else
            o = ops[$urandom_range(0, 5)];
            f = (o == 6'b000000) ? funcs[$urandom_range(0, 5)] : 6'($urandom);
`endif
            run_instr("random", o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.retire_cnt = 16'hFFFF;
        #1 release dut.retire_cnt;
        model_cnt = 16'hFFFF;
        checks++;
        if (retire_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got retire_cnt=%h, want ffff", retire_cnt);
        end
        run_instr("wrap_beq", 6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr("after_wrap_add", 6'b000000, 6'b100000, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_mem;
        test_beq;
        test_illegal;
        test_reset_mid_sw;
        test_random;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
